axi_rd_responder: RTL and testbench

//   AXI4 read-channel responder (slave) for the core's 128-bit AXI read master (ICache/DCache refills).

---
 rtl/axi_rd_responder.sv | 85 ++++++++
 tb/tb_axi_rd_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read responder returning bursts from an internal preloadable memory.
module axi_rd_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 4,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW = ADDR_WIDTH - OFF;
  localparam int MW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ld_data;
  logic [IW-1:0] waddr, nxt, ld_addr;
  logic [7:0] len, cnt;
  logic [1:0] burst;
  logic err, bad, ld_err, ld_oob, ld_last, fire_ar, fire_r;
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  always_comb begin
    bad = arsize != 3'(OFF) || arburst == 2'b11 ||
          (arburst == 2'b10 && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    // WRAP keeps the bits above len fixed and increments only the bits under the len mask
    nxt = burst == 2'b00 ? waddr :
          burst == 2'b10 ? (waddr & ~IW'(len)) | ((waddr + 1'b1) & IW'(len)) : waddr + 1'b1;
    ld_addr = state == IDLE ? IW'(araddr >> OFF) : nxt;
    ld_err = state == IDLE ? bad : err;
    ld_oob = ld_addr >= IW'(MEM_DEPTH);
    ld_data = (ld_err || ld_oob) ? '0 : mem[ld_addr[MW-1:0]];
    ld_last = state == IDLE ? arlen == 8'd0 : cnt + 8'd1 == len;
    arready = state == IDLE && !rst;
    rvalid = state == BURST;
    fire_ar = arvalid && arready;
    fire_r = rvalid && rready;
    state_n = fire_ar ? BURST : (fire_r && rlast) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // The next beat is read and registered on the accepting edge, so a stalled beat never re-reads memory
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rid <= '0;
      len <= '0;
      burst <= '0;
      err <= 1'b0;
      cnt <= '0;
      waddr <= '0;
      rdata <= '0;
      rresp <= '0;
      rlast <= 1'b0;
    end else if (fire_ar || (fire_r && !rlast)) begin
      if (fire_ar) begin
        rid <= arid;
        len <= arlen;
        burst <= arburst;
        err <= bad;
      end
      cnt <= fire_ar ? 8'd0 : cnt + 8'd1;
      waddr <= ld_addr;
      rdata <= ld_data;
      rresp <= (ld_err || ld_oob) ? 2'b10 : 2'b00;
      rlast <= ld_last;
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: directed checks of bursts, stalls, wrap/fixed stepping, errors and reset.
module tb_axi_rd_responder;
  logic clk = 0, rst = 1;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast, mem_we = 0;
  logic [3:0] arid = 0, rid;
  logic [31:0] araddr = 0;
  logic [7:0] arlen = 0;
  logic [2:0] arsize = 3'd4;
  logic [1:0] arburst = 2'b01, rresp;
  logic [127:0] rdata, mem_wdata = 0;
  logic [11:0] mem_waddr = 0;
  logic [127:0] a [4];
  logic [127:0] nw, lastw;
  int n_chk = 0, n_fail = 0;

  axi_rd_responder dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] adr, input logic [127:0] d);
    mem_we = 1; mem_waddr = adr; mem_wdata = d;
    step();
    mem_we = 0;
  endtask

  task automatic issue(input logic [31:0] adr, input logic [7:0] l, input logic [2:0] sz,
                       input logic [1:0] b, input logic [3:0] id);
    arvalid = 1; araddr = adr; arlen = l; arsize = sz; arburst = b; arid = id;
    chk("arready idle", arready, 1);
    step();
    arvalid = 0;
    chk("arready busy", arready, 0);
    chk("rid", rid, id);
  endtask

  task automatic beat(input string tag, input logic [127:0] d, input logic [1:0] resp, input logic last);
    rready = 1;
    chk({tag, " rvalid"}, rvalid, 1);
    chk({tag, " rdata"}, rdata, d);
    chk({tag, " rresp"}, rresp, resp);
    chk({tag, " rlast"}, rlast, last);
    step();
  endtask

  task automatic stall_beat(input string tag, input logic [127:0] d, input logic last);
    rready = 0;
    chk({tag, " rdata pre"}, rdata, d);
    step();
    chk({tag, " rdata held"}, rdata, d);
    chk({tag, " rlast held"}, rlast, last);
    beat(tag, d, 2'b00, last);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " rvalid low"}, rvalid, 0);
    chk({tag, " arready back"}, arready, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) a[i] = {4{32'hA000_0000 | 32'(i)}};
    nw = {4{32'h5EED_0001}};
    lastw = {4{32'hBEEF_0FFF}};
    #2;
    chk("rst rvalid", rvalid, 0);
    chk("rst arready", arready, 0);
    chk("rst rdata", rdata, 0);
    chk("rst rlast", rlast, 0);
    step();
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) wr(12'(i), a[i]);
    wr(12'd4095, lastw);

    issue(32'h00, 8'd3, 3'd4, 2'b01, 4'd5);
    for (int i = 0; i < 4; i++) beat("incr", a[i], 2'b00, i == 3);
    idle_chk("incr");

    issue(32'h00, 8'd3, 3'd4, 2'b01, 4'd6);
    for (int i = 0; i < 4; i++) stall_beat("stall", a[i], i == 3);
    idle_chk("stall");

    issue(32'h20, 8'd3, 3'd4, 2'b10, 4'd1);
    beat("wrap0", a[2], 2'b00, 0);
    beat("wrap1", a[3], 2'b00, 0);
    beat("wrap2", a[0], 2'b00, 0);
    beat("wrap3", a[1], 2'b00, 1);
    idle_chk("wrap");

    issue(32'h10, 8'd2, 3'd4, 2'b00, 4'd2);
    for (int i = 0; i < 3; i++) beat("fixed", a[1], 2'b00, i == 2);
    idle_chk("fixed");

    issue(32'hFFF0, 8'd1, 3'd4, 2'b01, 4'd3);
    beat("edge ok", lastw, 2'b00, 0);
    beat("edge oob", 128'd0, 2'b10, 1);
    idle_chk("edge");

    issue(32'h00, 8'd2, 3'd2, 2'b01, 4'd4);
    for (int i = 0; i < 3; i++) beat("badsize", 128'd0, 2'b10, i == 2);
    issue(32'h00, 8'd2, 3'd4, 2'b11, 4'd4);
    for (int i = 0; i < 3; i++) beat("badburst", 128'd0, 2'b10, i == 2);
    issue(32'h00, 8'd2, 3'd4, 2'b10, 4'd4);
    for (int i = 0; i < 3; i++) beat("badwrap", 128'd0, 2'b10, i == 2);
    issue(32'h00, 8'd0, 3'd4, 2'b01, 4'd7);
    beat("recover", a[0], 2'b00, 1);
    idle_chk("recover");

    mem_we = 1; mem_waddr = 12'd0; mem_wdata = nw;
    issue(32'h00, 8'd1, 3'd4, 2'b00, 4'd8);
    mem_we = 0;
    beat("wr old", a[0], 2'b00, 0);
    beat("wr new", nw, 2'b00, 1);

    issue(32'h00, 8'd7, 3'd4, 2'b01, 4'd2);
    beat("pre rst", nw, 2'b00, 0);
    chk("beat1 data", rdata, a[1]);
    rst = 1;
    #1;
    chk("midrst rvalid", rvalid, 0);
    chk("midrst arready", arready, 0);
    chk("midrst rlast", rlast, 0);
    step();
    rst = 0;
    rready = 0;
    #1;
    issue(32'h30, 8'd0, 3'd4, 2'b01, 4'd9);
    beat("post rst", a[3], 2'b00, 1);
    idle_chk("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
